// File: rtl/lin2log_encoder_if.sv
// Handshake bundle between the linear sample source, the lin2log encoder
// and the downstream log-domain consumer.
//   lin_in / in_valid / in_ready            : upstream sample handshake
//   log_out / log_valid / sign_out          : encoded result
//   out_valid / out_ready                   : downstream result handshake
// The encoder connects through the slave modport; a driver or bench uses master.
interface lin2log_encoder_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] lin_in;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH:0]   log_out;
   logic             log_valid;
   logic             sign_out;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  lin_in, in_valid, out_ready,
      output in_ready, log_out, log_valid, sign_out, out_valid
   );

   modport master (
      output lin_in, in_valid, out_ready,
      input  in_ready, log_out, log_valid, sign_out, out_valid
   );
endinterface

// File: rtl/lin2log_encoder.sv
// Linear-to-log encoder (Mitchell approximation) for the log-domain multiply
// path. A signed linear sample is turned into a signed fixed-point log2 of
// its magnitude, a separate sign bit, and a log-valid flag (low for zero).
// Leading-one normalisation runs one bit per cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; aborts any conversion or held result
//   bus  - slave modport of lin2log_encoder_if (lin_in/in_valid/in_ready on the
//          input side; log_out/log_valid/sign_out/out_valid/out_ready on output)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a sample, in_ready high
// NORM  | shifting mag left until its MSB is set, k tracks the exponent
// DONE  | result held on the outputs until out_ready
module lin2log_encoder #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 12
) (
   input  logic clk,
   input  logic rst,
   lin2log_encoder_if.slave bus
);
   localparam int KW = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] NORM = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] mag;
   logic [KW-1:0]    k;
   logic             sign_r;
   logic [WIDTH:0]   log_r;
   logic             log_valid_r;
   logic             sign_out_r;
   logic             out_valid_r;

   logic [WIDTH-1:0] abs_in;
   logic             in_zero;
   logic [WIDTH:0]   int_ext;
   logic [WIDTH:0]   log_next;

   // Magnitude of the incoming sample; the most negative code maps onto
   // 2^(WIDTH-1), which is still representable as unsigned.
   always_comb begin
      abs_in  = bus.lin_in;
      if (bus.lin_in[WIDTH-1]) begin
         abs_in = ~bus.lin_in + 1'b1;
      end
      in_zero = (bus.lin_in == '0);
   end

   // Integer part k-FRAC sits above the FRAC mantissa bits below the leading
   // one. The shift leaves the low FRAC bits zero, so the add is a merge.
   always_comb begin
      int_ext  = {{(WIDTH+1-KW){1'b0}}, k} - (WIDTH+1)'(FRAC);
      log_next = (int_ext << FRAC)
               + {{(WIDTH+1-FRAC){1'b0}}, mag[WIDTH-2 -: FRAC]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mag         <= '0;
         k           <= '0;
         sign_r      <= 1'b0;
         log_r       <= '0;
         log_valid_r <= 1'b0;
         sign_out_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mag    <= abs_in;
                  sign_r <= bus.lin_in[WIDTH-1];
                  k      <= KW'(WIDTH-1);
                  if (in_zero) begin
                     log_r       <= '0;
                     log_valid_r <= 1'b0;
                     sign_out_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= NORM;
                  end
               end
            end
            NORM: begin
               if (!mag[WIDTH-1]) begin
                  mag <= mag << 1;
                  k   <= k - 1'b1;
               end else begin
                  log_r       <= log_next;
                  log_valid_r <= 1'b1;
                  sign_out_r  <= sign_r;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  log_r       <= '0;
                  log_valid_r <= 1'b0;
                  sign_out_r  <= 1'b0;
                  out_valid_r <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.log_out   = log_r;
   assign bus.log_valid = log_valid_r;
   assign bus.sign_out  = sign_out_r;
   assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_lin2log_encoder.sv
// Bench for lin2log_encoder: directed vectors plus a few samples against a
// Mitchell model; a monitor pops expected results from a queue on each
// output handshake.
module tb_lin2log_encoder;
   typedef struct {
      logic [15:0] lin;
      logic [16:0] log_v;
      logic        lv;
      logic        sgn;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   exp_t exp_q[$];

   lin2log_encoder_if #(.WIDTH(16)) bus ();

   lin2log_encoder #(.WIDTH(16), .FRAC(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   // Monitor: every accepted result is compared against the queue head.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got log_out %h with no expected entry", bus.log_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("log_out[%h]", e.lin), 32'(bus.log_out), 32'(e.log_v));
            chk($sformatf("log_valid[%h]", e.lin), 32'(bus.log_valid), 32'(e.lv));
            chk($sformatf("sign_out[%h]", e.lin), 32'(bus.sign_out), 32'(e.sgn));
         end
      end
   end

   function automatic void model(input logic [15:0] v, output logic [16:0] lg,
                                 output logic s, output int lat);
      int m, p, fr, val;
      s = v[15];
      m = v[15] ? (65536 - int'(v)) : int'(v);
      p = 15;
      while (p > 0 && m < (1 << p)) p--;
      fr  = ((m - (1 << p)) * 4096) / (1 << p);
      val = (p - 12) * 4096 + fr;
      lg  = val[16:0];
      lat = 16 - p;
   endfunction

   // Issue one sample (called at posedge+1 with the DUT idle), check latency,
   // then step past the handshake edge when out_ready is high.
   task automatic send(input logic [15:0] v, input logic [16:0] lg, input logic lv,
                       input logic s, input int lat);
      exp_t e;
      int   cnt;
      chk($sformatf("in_ready_before[%h]", v), 32'(bus.in_ready), 32'd1);
      e.lin = v; e.log_v = lg; e.lv = lv; e.sgn = s;
      exp_q.push_back(e);
      bus.lin_in   = v;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      cnt = 0;
      while (!bus.out_valid && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk($sformatf("latency[%h]", v), 32'(cnt), 32'(lat));
      if (bus.out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [16:0] lg;
      logic        s;
      int          lat;
      logic [15:0] v;

      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.lin_in    = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_log_out", 32'(bus.log_out), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;

      send(16'h1000, 17'h00000, 1'b1, 1'b0, 4);
      send(16'h2000, 17'h01000, 1'b1, 1'b0, 3);
      send(16'hE800, 17'h00800, 1'b1, 1'b1, 4);
      send(16'h0001, 17'h14000, 1'b1, 1'b0, 16);
      send(16'h8000, 17'h03000, 1'b1, 1'b1, 1);
      send(16'h7FFF, 17'h02FFF, 1'b1, 1'b0, 2);
      send(16'h0000, 17'h00000, 1'b0, 1'b0, 0);
      send(16'hFFFF, 17'h14000, 1'b1, 1'b1, 16);

      // Back-to-back samples against the Mitchell model.
      for (int i = 0; i < 8; i++) begin
         v = 16'($urandom_range(1, 65535));
         model(v, lg, s, lat);
         send(v, lg, 1'b1, s, lat);
      end

      // Backpressure: hold the result for 10 cycles while poking in_valid.
      bus.out_ready = 1'b0;
      send(16'h2000, 17'h01000, 1'b1, 1'b0, 3);
      for (int i = 0; i < 10; i++) begin
         bus.lin_in   = 16'h0001;
         bus.in_valid = (i % 2 == 0);
         @(posedge clk); #1;
         chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_log_out", 32'(bus.log_out), 32'h01000);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_out_valid", 32'(bus.out_valid), 32'd0);
      chk("release_log_valid", 32'(bus.log_valid), 32'd0);
      chk("release_log_out", 32'(bus.log_out), 32'd0);
      chk("release_in_ready", 32'(bus.in_ready), 32'd1);
      repeat (20) @(posedge clk);
      #1;
      chk("no_ghost_output", 32'(bus.out_valid), 32'd0);

      // Reset partway through normalising 16'h0001.
      bus.lin_in   = 16'h0001;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("mid_norm_busy", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_log_out", 32'(bus.log_out), 32'd0);
      rst = 1'b0;
      #1;
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) chk("abort_stale_out_valid", 32'(bus.out_valid), 32'd0);
      end

      // One more conversion after the abort.
      send(16'h2000, 17'h01000, 1'b1, 1'b0, 3);
      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
